// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch sequencer:
//   - byte/word widths and queue/window geometry
//   - Y86-64 icode constants (IHALT .. IPOPQ)
//   - request FSM state enum
//   - word_byte(): little-endian byte select from a 64-bit memory word
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 64;
  localparam int WORD_BYTES = 8;
  localparam int WIN_BYTES  = 10;   // longest instruction, width of inst_bytes in bytes

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Request FSM: one memory request in flight at most.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DROP  = 2'd3
  } fetch_state_t;

  // Byte k of a little-endian word lives at [8k+7:8k].
  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                  input logic [2:0]        k);
    return w[{k, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Bus bundle of the fetch sequencer.
//   memory side : mem_req_valid/ready/addr (request), mem_rsp_valid/data (response)
//   decode side : inst_valid/ready with inst_bytes, inst_pc, inst_len, inst_err
//   control     : redirect_valid/redirect_pc (flush + restart)
// Modports:
//   master - the fetch sequencer itself
//   slave  - the surrounding memory / decode / redirect logic
//
// Handshake rule for every valid/ready pair here: a transfer happens on a rising
// clock edge where valid and ready are both 1; a producer holds its payload
// stable while valid is 1 and not yet accepted. mem_rsp_valid has no ready: the
// sequencer always takes (or discards) a response the cycle it is presented.
// -----------------------------------------------------------------------------
interface fetch_sequencer_if;

  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;

  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;

  logic        inst_valid;
  logic        inst_ready;
  logic [79:0] inst_bytes;
  logic [63:0] inst_pc;
  logic [3:0]  inst_len;
  logic        inst_err;

  logic        redirect_valid;
  logic [63:0] redirect_pc;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data,
    output inst_valid, inst_bytes, inst_pc, inst_len, inst_err,
    input  inst_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data,
    input  inst_valid, inst_bytes, inst_pc, inst_len, inst_err,
    output inst_ready,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_len_decode.sv
// -----------------------------------------------------------------------------
// fetch_len_decode
// Combinational map from an instruction's icode (high nibble of byte 0) to its
// length in bytes and an invalid-icode flag.
//   icode : in  4  - byte0[7:4]
//   len   : out 4  - 1..10
//   err   : out 1  - icode is not a defined instruction (C..F); len is then 1
// -----------------------------------------------------------------------------
module fetch_len_decode
  import fetch_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       err
);

  always_comb begin
    len = 4'd1;
    err = 1'b0;
    case (icode)
      IHALT, INOP, IRET:             len = 4'd1;
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:  len = 4'd2;
      IJXX, ICALL:                   len = 4'd9;
      IIRMOVQ, IRMMOVQ, IMRMOVQ:     len = 4'd10;
      default: begin
        // Undefined icode: consume a single byte so the stream keeps moving.
        len = 4'd1;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Fetches 8-byte aligned words from memory into a 16-byte queue and presents
// whole Y86-64 instructions (1..10 bytes) to the align/split stage.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (master)    : memory request/response, instruction handshake, redirect
//   dbg_state       : current request FSM state
//   perf_inst_cnt   : (FETCH_PERF_EN only) completed instruction handshakes
//   perf_stall_cnt  : (FETCH_PERF_EN only) cycles with inst_ready=1, inst_valid=0
//
// Parameters:
//   RESET_PC  : first fetch PC after reset
//   BUF_BYTES : queue capacity in bytes, only 16 is supported
//
// Optional feature macro: FETCH_PERF_EN (adds the two performance counters).
//
// Queue layout: q[0] is the oldest byte (byte0 of the current instruction).
// A pop shifts the queue down by inst_len; a push appends the useful bytes of
// the returned word right after the bytes that survive the pop.
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          BUF_BYTES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_sequencer_if.master bus,
  output fetch_state_t      dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_inst_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [BYTE_W-1:0] q [BUF_BYTES];
  logic [4:0]        count;
  logic [63:0]       pc;
  logic [63:0]       fetch_addr;
  fetch_state_t      state;
  logic              req_valid;

  // ---------------------------------------------------------------------------
  // Length decode of the head instruction
  // ---------------------------------------------------------------------------
  logic [3:0] len;
  logic       err;

  fetch_len_decode u_len_decode (
    .icode (q[0][7:4]),
    .len   (len),
    .err   (err)
  );

  // ---------------------------------------------------------------------------
  // Handshake, pop and push bookkeeping
  // ---------------------------------------------------------------------------
  logic       inst_valid;
  logic       handshake;
  logic [4:0] pop_n;
  logic       push_en;
  logic [2:0] push_off;
  logic [3:0] push_n;
  logic [4:0] keep_n;
  logic       free_ok;

  // A redirect hides the head instruction for the cycle it is flushed.
  assign inst_valid = ({1'b0, len} <= count) && !bus.redirect_valid;
  assign handshake  = inst_valid && bus.inst_ready;
  assign pop_n      = handshake ? {1'b0, len} : 5'd0;
  assign keep_n     = count - pop_n;

  // The fetch address is only unaligned for the first word after a reset or
  // redirect; bytes below it in that word belong to earlier code.
  assign push_en  = (state == S_WAIT) && bus.mem_rsp_valid && !bus.redirect_valid;
  assign push_off = fetch_addr[2:0];
  assign push_n   = 4'd8 - {1'b0, push_off};

  // Space check counts bytes leaving this cycle. Count only shrinks while a
  // request is outstanding, so the space reserved here is still there when
  // the response arrives.
  assign free_ok = (6'(BUF_BYTES) - {1'b0, count} + {1'b0, pop_n}) >= 6'd8;

  // ---------------------------------------------------------------------------
  // Next queue contents: shift out popped bytes, append pushed bytes
  // ---------------------------------------------------------------------------
  logic [BYTE_W-1:0] q_next [BUF_BYTES];
  logic [4:0]        count_next;

  always_comb begin
    logic [4:0] src;
    logic [4:0] rel;
    for (int i = 0; i < BUF_BYTES; i++) begin
      q_next[i] = '0;
      src = 5'(i) + pop_n;
      if (src < 5'(BUF_BYTES)) q_next[i] = q[src[3:0]];
      rel = 5'(i) - keep_n;
      if (push_en && (5'(i) >= keep_n) && (rel < {1'b0, push_n}))
        q_next[i] = word_byte(bus.mem_rsp_data, push_off + rel[2:0]);
    end
    count_next = keep_n + (push_en ? {1'b0, push_n} : 5'd0);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: queue, count, instruction PC, fetch address
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_BYTES; i++) q[i] <= '0;
      count      <= '0;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
    end else if (bus.redirect_valid) begin
      // Flush wins over any push or pop in the same cycle.
      for (int i = 0; i < BUF_BYTES; i++) q[i] <= '0;
      count      <= '0;
      pc         <= bus.redirect_pc;
      fetch_addr <= bus.redirect_pc;
    end else begin
      for (int i = 0; i < BUF_BYTES; i++) q[i] <= q_next[i];
      count <= count_next;
      if (handshake) pc <= pc + {60'd0, len};
      // Step to the next aligned word; clears the first-word offset.
      if (push_en) fetch_addr <= {fetch_addr[63:3], 3'b000} + 64'd8;
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!bus.redirect_valid && free_ok) begin
            state     <= S_ISSUE;
            req_valid <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (bus.mem_req_ready) begin
            // Accepted together with a redirect: its response is stale.
            req_valid <= 1'b0;
            state     <= bus.redirect_valid ? S_DROP : S_WAIT;
          end else if (bus.redirect_valid) begin
            req_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_WAIT: begin
          // A response arriving with a redirect is consumed (and discarded by
          // push_en), so nothing remains to drop.
          if (bus.mem_rsp_valid)       state <= S_IDLE;
          else if (bus.redirect_valid) state <= S_DROP;
        end
        S_DROP: begin
          // Further redirects keep waiting for the one stale response.
          if (bus.mem_rsp_valid) state <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [79:0] window;

  always_comb begin
    window = '0;
    for (int k = 0; k < WIN_BYTES; k++) begin
      if (4'(k) < len) window[79 - 8*k -: 8] = q[k];
    end
  end

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = {fetch_addr[63:3], 3'b000};
  assign bus.inst_valid    = inst_valid;
  assign bus.inst_bytes    = window;
  assign bus.inst_pc       = pc;
  assign bus.inst_len      = len;
  assign bus.inst_err      = err;
  assign dbg_state         = state;

`ifdef FETCH_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (wrap naturally at 2^32)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_inst_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (handshake)                      perf_inst_cnt  <= perf_inst_cnt + 32'd1;
      if (bus.inst_ready && !inst_valid)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer. A byte-array memory answers word
// requests with random latency; the expected instruction stream is computed
// from the memory contents and the instruction length table, pushed into
// exp_q whenever the bench resets or redirects, and popped by a monitor on
// every instruction handshake. Optional counters checked when FETCH_PERF_EN
// is defined.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam logic [63:0] RESET_PC = 64'h0;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_sequencer_if bus ();
  fetch_state_t dbg_state;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_inst_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fetch_sequencer #(.RESET_PC(RESET_PC), .BUF_BYTES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef FETCH_PERF_EN
    ,
    .perf_inst_cnt  (perf_inst_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // ---------------------------------------------------------------------------
  // Bench state
  // ---------------------------------------------------------------------------
  logic [7:0]   mem [4096];
  int           len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
  logic [148:0] exp_q [$];     // {pc, len, err, bytes}
  logic [63:0]  exp_req_addr;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           req_cnt = 0;
  int           hs_cnt  = 0;
  int           stall_cnt = 0;
  int           err_seen = 0;
  int           ready_mode = 0;   // 0: inst_ready low, 1: high, 2: random
  int           lat_min = 0;
  int           lat_max = 3;
  bit           hold_rsp = 1'b0;

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_at(input logic [63:0] a);
    return mem[a[11:0]];
  endfunction

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = mem_at(a + 64'(k));
    return w;
  endfunction

  // Reference model: walk the instruction stream from 'start'.
  task automatic push_stream(input logic [63:0] start, input int n);
    logic [63:0] p;
    logic [7:0]  b0;
    logic [79:0] win;
    int          l;
    p = start;
    for (int i = 0; i < n; i++) begin
      b0  = mem_at(p);
      l   = len_tab[b0[7:4]];
      win = '0;
      for (int k = 0; k < l; k++) win[79 - 8*k -: 8] = mem_at(p + 64'(k));
      exp_q.push_back({p, 4'(l), (b0[7:4] >= 4'hC), win});
      p = p + 64'(l);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_redirect(input logic [63:0] pc);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    exp_q.delete();
    push_stream(pc, 300);
    exp_req_addr = {pc[63:3], 3'b000};
    req_cnt      = 0;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
  endtask

  // inst_ready driver
  initial begin
    bus.inst_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.inst_ready = 1'b0;
        1:       bus.inst_ready = 1'b1;
        default: bus.inst_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Memory model: one request in flight, random accept and latency.
  initial begin
    logic        accept;
    logic [63:0] acc_addr;
    logic [63:0] paddr;
    bit          pending;
    int          lat;
    pending = 1'b0;
    lat     = 0;
    paddr   = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      accept   = rst_n && bus.mem_req_valid && bus.mem_req_ready;
      acc_addr = bus.mem_req_addr;
      @(posedge clk); #1;
      bus.mem_rsp_valid = 1'b0;
      if (accept) begin
        pending = 1'b1;
        paddr   = acc_addr;
        lat     = $urandom_range(lat_min, lat_max);
      end
      if (pending && !hold_rsp) begin
        if (lat == 0) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = mem_word(paddr);
          pending = 1'b0;
        end else begin
          lat--;
        end
      end
      bus.mem_req_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    logic [148:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.redirect_valid)
          check("valid_in_redirect", 192'(bus.inst_valid), 192'(0));
        if (bus.inst_valid && bus.inst_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            check("inst_unexpected", 192'(bus.inst_pc), 192'(64'hFFFF_FFFF_FFFF_FFFF));
          end else begin
            e = exp_q.pop_front();
            if (e[80]) err_seen++;
            check("inst", 192'({bus.inst_pc, bus.inst_len, bus.inst_err, bus.inst_bytes}),
                  192'(e));
          end
        end
        if (bus.inst_ready && !bus.inst_valid) stall_cnt++;
        if (bus.mem_req_valid && bus.mem_req_ready && !bus.redirect_valid) begin
          check("req_addr", 192'(bus.mem_req_addr), 192'(exp_req_addr));
          exp_req_addr = exp_req_addr + 64'd8;
          req_cnt++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h10; mem[1] = 8'h30; mem[2] = 8'hF3; mem[3] = 8'h0A;
    for (int i = 4; i <= 10; i++) mem[i] = 8'h00;
    mem[12'h200] = 8'hE0;

    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    exp_req_addr       = RESET_PC;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_inst_valid", 192'(bus.inst_valid), 192'(0));
    check("rst_req_valid",  192'(bus.mem_req_valid), 192'(0));
    check("rst_inst_bytes", 192'(bus.inst_bytes), 192'(0));
    check("rst_inst_pc",    192'(bus.inst_pc), 192'(RESET_PC));
    check("rst_state",      192'(dbg_state), 192'(S_IDLE));
    push_stream(RESET_PC, 300);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Stream from reset: 10 / 30 F3 0A 00...
    ready_mode = 2;
    repeat (80) @(posedge clk);

    // Unaligned redirect: request at 0x10, first instruction at 0x13
    do_redirect(64'h13);
    repeat (60) @(posedge clk);

    // Full queue with no consumer: exactly two words fetched, then silence
    ready_mode = 0;
    do_redirect(64'h40);
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("full_req_cnt",   192'(req_cnt), 192'(2));
    check("full_req_valid", 192'(bus.mem_req_valid), 192'(0));
    ready_mode = 2;
    repeat (40) @(posedge clk);

    // Invalid icode 0xE0
    do_redirect(64'h200);
    repeat (40) @(posedge clk);

    // Redirect while a response is outstanding
    hold_rsp = 1'b1;
    for (int i = 0; i < 200 && dbg_state != S_WAIT; i++) @(negedge clk);
    check("reach_wait", 192'(dbg_state), 192'(S_WAIT));
    do_redirect(64'h3A5);
    @(negedge clk);
    check("drop_state", 192'(dbg_state), 192'(S_DROP));
    hold_rsp = 1'b0;
    repeat (60) @(posedge clk);

    // Random redirects and traffic
    for (int r = 0; r < 15; r++) begin
      lat_max = $urandom_range(0, 5);
      do_redirect(64'($urandom_range(0, 3500)));
      repeat ($urandom_range(10, 60)) @(posedge clk);
    end

    // Quiesce and final checks
    ready_mode = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("progress", 192'(hs_cnt >= 50), 192'(1));
    check("err_seen", 192'(err_seen > 0), 192'(1));
`ifdef FETCH_PERF_EN
    check("perf_inst_cnt",  192'(perf_inst_cnt),  192'(32'(hs_cnt)));
    check("perf_stall_cnt", 192'(perf_stall_cnt), 192'(32'(stall_cnt)));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
